// File: rtl/mc_control.sv
// Multicycle CPU control FSM: decodes IR opcode/funct into ALU select, mux selects and enables.
// Optional bne support is compiled in when MC_CONTROL_BNE_EN is defined.
module mc_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zf,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [1:0] pc_source,
  output logic [2:0] alu_switch,
  output logic       instr_done,
  output logic [3:0] state
);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

`ifdef MC_CONTROL_BNE_EN
  localparam bit BneEn = 1'b1;
`else
  localparam bit BneEn = 1'b0;
`endif

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StIexec  = 4'd10,
    StIwb    = 4'd11
  } state_e;

  state_e state_q, state_d;

  logic       is_bne;
  logic [2:0] r_switch;
  logic       r_valid;

  assign is_bne = BneEn && (opcode == OpBne);

  always_comb begin
    r_valid  = 1'b1;
    r_switch = ALU_ADD;
    case (funct)
      6'h20:   r_switch = ALU_ADD;
      6'h22:   r_switch = ALU_SUB;
      6'h24:   r_switch = ALU_AND;
      6'h25:   r_switch = ALU_OR;
      6'h26:   r_switch = ALU_XOR;
      6'h2A:   r_switch = ALU_SLT;
      6'h00:   r_switch = ALU_SLL;
      6'h02:   r_switch = ALU_SRL;
      default: r_valid  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLw, OpSw:            state_d = StMemAdr;
          OpRtype:               state_d = StExec;
          OpBeq:                 state_d = StBranch;
          OpJ:                   state_d = StJump;
          OpAddi, OpAndi, OpOri: state_d = StIexec;
          default:               state_d = is_bne ? StBranch : StFetch;
        endcase
      end
      StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  state_d = StMemWb;
      StExec:   state_d = StRwb;
      StIexec:  state_d = StIwb;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_zero   = 1'b0;
    pc_source  = 2'b00;
    alu_switch = ALU_AND;
    instr_done = 1'b0;
    case (state_q)
      StFetch: begin
        mem_read   = 1'b1;
        ir_write   = 1'b1;
        pc_en      = 1'b1;
        alu_src_b  = 2'b01;
        alu_switch = ALU_ADD;
      end
      StDecode: begin
        alu_src_b  = 2'b11;
        alu_switch = ALU_ADD;
        case (opcode)
          OpLw, OpSw, OpRtype, OpBeq, OpJ, OpAddi, OpAndi, OpOri: instr_done = 1'b0;
          default: instr_done = ~is_bne;
        endcase
      end
      StMemAdr: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_switch = ALU_ADD;
      end
      StMemRd: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      StMemWr: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = 1'b1;
      end
      StExec: begin
        alu_src_a  = 1'b1;
        alu_switch = r_switch;
      end
      StRwb: begin
        // Unknown funct still completes, but must not corrupt the regfile.
        reg_dst    = 1'b1;
        reg_write  = r_valid;
        instr_done = 1'b1;
      end
      StIexec: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          OpAndi: begin
            alu_switch = ALU_AND;
            ext_zero   = 1'b1;
          end
          OpOri: begin
            alu_switch = ALU_OR;
            ext_zero   = 1'b1;
          end
          default: alu_switch = ALU_ADD;
        endcase
      end
      StIwb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        alu_src_a  = 1'b1;
        alu_switch = ALU_SUB;
        pc_source  = 2'b01;
        pc_en      = is_bne ? ~zf : zf;
        instr_done = 1'b1;
      end
      StJump: begin
        pc_source  = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      ext_zero   = 1'b0;
      pc_source  = 2'b00;
      alu_switch = ALU_AND;
      instr_done = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed self-checking bench for mc_control; outputs are compared as one packed control word.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zf;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, ext_zero, instr_done;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_switch;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  mc_control dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .zf         (zf),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ext_zero   (ext_zero),
    .pc_source  (pc_source),
    .alu_switch (alu_switch),
    .instr_done (instr_done),
    .state      (state)
  );

  always #5 clk = ~clk;

  // {pc_en,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,
  //  alu_src_a,alu_src_b,ext_zero,pc_source,alu_switch,instr_done,state}
  logic [21:0] ctl;
  assign ctl = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, ext_zero, pc_source, alu_switch, instr_done, state};

  function automatic logic [21:0] mk(input logic pe, input logic io, input logic mr,
                                     input logic mw, input logic irw, input logic rd,
                                     input logic m2r, input logic rw, input logic asa,
                                     input logic [1:0] asb, input logic ez,
                                     input logic [1:0] ps, input logic [2:0] sw,
                                     input logic dn, input logic [3:0] st);
    return {pe, io, mr, mw, irw, rd, m2r, rw, asa, asb, ez, ps, sw, dn, st};
  endfunction

  logic [21:0] v_fetch, v_decode;
  initial begin
    v_fetch  = mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 0, 2'b00, 3'b010, 0, 4'd0);
    v_decode = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 2'b00, 3'b010, 0, 4'd1);
  end

  task automatic test_reset();
    rst = 1'b1; opcode = 6'h3F; funct = 6'h00; zf = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ctl !== 22'h0) begin
      errors++; $display("FAIL reset_hold got %h want %h", ctl, 22'h0);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ctl !== v_fetch) begin
      errors++; $display("FAIL reset_release got %h want %h", ctl, v_fetch);
    end
  endtask

  task automatic test_lw();
    logic [21:0] exp [5];
    exp[0] = v_fetch;
    exp[1] = v_decode;
    exp[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b010, 0, 4'd2);
    exp[3] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 4'd3);
    exp[4] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 2'b00, 3'b000, 1, 4'd4);
    opcode = 6'h23;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ctl !== exp[i]) begin
        errors++; $display("FAIL lw_cyc%0d got %h want %h", i, ctl, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw();
    logic [21:0] exp [4];
    exp[0] = v_fetch;
    exp[1] = v_decode;
    exp[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b010, 0, 4'd2);
    exp[3] = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 4'd5);
    opcode = 6'h2B;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ctl !== exp[i]) begin
        errors++; $display("FAIL sw_cyc%0d got %h want %h", i, ctl, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rtype();
    logic [5:0]  fn  [3];
    logic [2:0]  sw  [3];
    logic        rw  [3];
    logic [21:0] exp [4];
    fn[0] = 6'h22; sw[0] = 3'b110; rw[0] = 1'b1;
    fn[1] = 6'h02; sw[1] = 3'b100; rw[1] = 1'b1;
    fn[2] = 6'h3F; sw[2] = 3'b010; rw[2] = 1'b0;
    opcode = 6'h00;
    for (int t = 0; t < 3; t++) begin
      funct  = fn[t];
      exp[0] = v_fetch;
      exp[1] = v_decode;
      exp[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, sw[t], 0, 4'd6);
      exp[3] = mk(0, 0, 0, 0, 0, 1, 0, rw[t], 0, 2'b00, 0, 2'b00, 3'b000, 1, 4'd7);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ctl !== exp[i]) begin
          errors++; $display("FAIL rtype_f%h_cyc%0d got %h want %h", fn[t], i, ctl, exp[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_beq();
    logic [21:0] exp [3];
    opcode = 6'h04;
    for (int t = 0; t < 2; t++) begin
      zf     = (t == 0);
      exp[0] = v_fetch;
      exp[1] = v_decode;
      exp[2] = mk(zf, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b01, 3'b110, 1, 4'd8);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ctl !== exp[i]) begin
          errors++; $display("FAIL beq_zf%0d_cyc%0d got %h want %h", zf, i, ctl, exp[i]);
        end
        @(negedge clk);
      end
    end
    checks++;
    if (ctl !== v_fetch) begin
      errors++; $display("FAIL beq_return got %h want %h", ctl, v_fetch);
    end
    zf = 1'b0;
  endtask

  task automatic test_imm();
    logic [5:0]  op [3];
    logic [2:0]  sw [3];
    logic        ez [3];
    logic [21:0] exp [4];
    op[0] = 6'h0D; sw[0] = 3'b001; ez[0] = 1'b1;
    op[1] = 6'h0C; sw[1] = 3'b000; ez[1] = 1'b1;
    op[2] = 6'h08; sw[2] = 3'b010; ez[2] = 1'b0;
    for (int t = 0; t < 3; t++) begin
      opcode = op[t];
      exp[0] = v_fetch;
      exp[1] = v_decode;
      exp[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, ez[t], 2'b00, sw[t], 0, 4'd10);
      exp[3] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 2'b00, 3'b000, 1, 4'd11);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ctl !== exp[i]) begin
          errors++; $display("FAIL imm_op%h_cyc%0d got %h want %h", op[t], i, ctl, exp[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_jump();
    logic [21:0] exp [3];
    exp[0] = v_fetch;
    exp[1] = v_decode;
    exp[2] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 3'b000, 1, 4'd9);
    opcode = 6'h02;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ctl !== exp[i]) begin
        errors++; $display("FAIL jump_cyc%0d got %h want %h", i, ctl, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_bne();
    logic [21:0] exp [3];
    opcode = 6'h05; zf = 1'b0;
    exp[0] = v_fetch;
`ifdef MC_CONTROL_BNE_EN
    exp[1] = v_decode;
    exp[2] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b01, 3'b110, 1, 4'd8);
`else
    exp[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 2'b00, 3'b010, 1, 4'd1);
    exp[2] = v_fetch;
`endif
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ctl !== exp[i]) begin
        errors++; $display("FAIL bne_cyc%0d got %h want %h", i, ctl, exp[i]);
      end
      @(negedge clk);
    end
`ifndef MC_CONTROL_BNE_EN
    // Third cycle above was a new FETCH; finish that fetch as an illegal op.
    opcode = 6'h3F;
    @(negedge clk);
`endif
  endtask

  task automatic test_reset_mid_memrd();
    opcode = 6'h23;
    repeat (3) @(negedge clk);
    checks++;
    if (state !== 4'd3) begin
      errors++; $display("FAIL mid_memrd_state got %0d want %0d", state, 3);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ctl !== 22'h0) begin
      errors++; $display("FAIL mid_memrd_async got %h want %h", ctl, 22'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ctl !== v_fetch) begin
      errors++; $display("FAIL mid_memrd_release got %h want %h", ctl, v_fetch);
    end
    opcode = 6'h3F;
    @(negedge clk);
    checks++;
    if (state !== 4'd1 || instr_done !== 1'b1 || reg_write !== 1'b0 || pc_en !== 1'b0) begin
      errors++;
      $display("FAIL illegal_decode got st=%0d dn=%b rw=%b pe=%b want st=1 dn=1 rw=0 pe=0",
               state, instr_done, reg_write, pc_en);
    end
    @(negedge clk);
    checks++;
    if (ctl !== v_fetch) begin
      errors++; $display("FAIL illegal_return got %h want %h", ctl, v_fetch);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_beq();
    test_imm();
    test_jump();
    test_bne();
    test_reset_mid_memrd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
